// File: rtl/alu_dispatch.sv
// PHV/ALU dispatch stage: captures a PHV and its action word, issues the action to an ALU,
// writes the ALU result back into one container and emits the updated PHV downstream.
module alu_dispatch #(
    parameter int STAGE_ID    = 0,
    parameter int ACTION_LEN  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CONT    = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]          action_in,
    input  logic                           phv_valid_in,
    output logic                           phv_ready_out,
    output logic [ACTION_LEN-1:0]          action_out,
    output logic                           action_valid_out,
    output logic [DATA_WIDTH-1:0]          operand_1_out,
    output logic [DATA_WIDTH-1:0]          operand_2_out,
    output logic [DATA_WIDTH-1:0]          operand_3_out,
    output logic [DATA_WIDTH-1:0]          operand_4_out,
    input  logic                           alu_ready_in,
    input  logic [DATA_WIDTH-1:0]          container_in,
    input  logic                           container_in_valid,
    output logic                           alu_result_ready,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
    output logic                           phv_valid_out,
    input  logic                           phv_ready_in,
    output logic                           timeout_err,
    output logic [31:0]                    pkt_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, OUT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                               state, state_nxt;
    logic [NUM_CONT-1:0][DATA_WIDTH-1:0]  phv_r;
    logic [ACTION_LEN-1:0]                action_r;
    logic [7:0]                           wait_cnt;

    logic [7:0] opcode;
    logic [2:0] op1_idx, op2_idx, op3_idx, dst_idx;
    logic [DATA_WIDTH-1:0] imm;
    logic use_imm, wait_expired;
    logic unused_bits;

    assign opcode  = action_r[63:56];
    assign op1_idx = action_r[55:53];
    assign op2_idx = action_r[52:50];
    assign op3_idx = action_r[49:47];
    assign dst_idx = action_r[46:44];
    assign imm     = action_r[DATA_WIDTH-1:0];
    assign unused_bits = ^{action_r[43:32], 32'(STAGE_ID)};

    assign use_imm = opcode inside {8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0E};
    // A result arriving on the last wait cycle takes priority over the timeout.
    assign wait_expired = (wait_cnt == WAIT_LAST) && !container_in_valid;

    assign action_out    = action_r;
    assign operand_1_out = phv_r[op1_idx];
    assign operand_2_out = use_imm ? imm : phv_r[op2_idx];
    assign operand_3_out = phv_r[op3_idx];
    assign operand_4_out = '0;
    assign phv_out       = phv_r;

    always_comb begin
        state_nxt        = state;
        phv_ready_out    = 1'b0;
        action_valid_out = 1'b0;
        alu_result_ready = 1'b0;
        phv_valid_out    = 1'b0;
        case (state)
            IDLE: begin
                phv_ready_out = 1'b1;
                if (phv_valid_in)
                    state_nxt = (action_in[63:56] == 8'h00) ? OUT : ISSUE;
            end
            ISSUE: begin
                action_valid_out = alu_ready_in;
                if (alu_ready_in) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                alu_result_ready = 1'b1;
                if (container_in_valid || wait_expired) state_nxt = OUT;
            end
            OUT: begin
                phv_valid_out = 1'b1;
                if (phv_ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phv_r       <= '0;
            action_r    <= '0;
            wait_cnt    <= '0;
            pkt_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= (state == WAIT_RES) && wait_expired;
            if (state == IDLE && phv_valid_in) begin
                phv_r    <= phv_in;
                action_r <= action_in;
            end
            // Counter idles at zero so it is already clear on every WAIT_RES entry.
            if (state == WAIT_RES) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (container_in_valid) phv_r[dst_idx] <= container_in;
            end else begin
                wait_cnt <= '0;
            end
            if (state == OUT && phv_ready_in) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

endmodule
